// File: rtl/rv32imf_obi_pkg.sv
// ============================================================================
// Module      : rv32imf_obi_pkg
// Description : Shared response type and constants for the OBI memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32imf_obi_pkg;

    localparam logic [5:0] OBI_ATOP_NONE = 6'h00;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    localparam obi_rsp_t c_RSP_IDLE = '{valid: 1'b0, rdata: 32'h0, err: 1'b0};

endpackage

`default_nettype wire

// File: rtl/rv32imf_obi_rsp_pipe.sv
// ============================================================================
// Module      : rv32imf_obi_rsp_pipe
// Description : Fixed-latency response delay line; never stalls, cleared on reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32imf_obi_rsp_pipe
    import rv32imf_obi_pkg::*;
#(
    parameter int unsigned STAGES = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  obi_rsp_t i_rsp,
    output obi_rsp_t o_rsp
);

    obi_rsp_t r_stage_q [STAGES];
    obi_rsp_t w_stage_d [STAGES];

    always_comb begin
        w_stage_d[0] = i_rsp;
        for (int i = 1; i < int'(STAGES); i++) begin
            w_stage_d[i] = r_stage_q[i-1];
        end
    end

    // In-flight responses are dropped outright on reset, never replayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_stage_q[i] <= c_RSP_IDLE;
            end
        end else begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_stage_q[i] <= w_stage_d[i];
            end
        end
    end

    assign o_rsp = r_stage_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/rv32imf_obi_mem_responder.sv
// ============================================================================
// Module      : rv32imf_obi_mem_responder
// Description : OBI slave backed by a word array with fixed response latency.
//               Optional macro RV32IMF_OBI_MEM_STALL_EN: one idle gnt cycle
//               after every accepted transfer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32imf_obi_mem_responder
    import rv32imf_obi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned RSP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    input  logic [5:0]  obi_atop_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o
);

    localparam int unsigned c_IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] c_SPAN  = 33'(MEM_WORDS) << 2;

    logic [31:0]        w_offset;
    logic               w_in_range;
    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_accept;
    logic               w_stall;
    obi_rsp_t           w_rsp_in;
    obi_rsp_t           w_rsp_out;

    logic [31:0] r_mem_q [MEM_WORDS];

    // Offset arithmetic wraps, so addresses below the base land out of range.
    assign w_offset   = obi_addr_i - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_SPAN);
    assign w_err      = !w_in_range || (obi_atop_i != OBI_ATOP_NONE);
    assign w_idx      = w_offset[c_IDX_W+1:2];

    assign obi_gnt_o  = obi_req_i && !rst && !w_stall;
    assign w_accept   = obi_req_i && obi_gnt_o;

`ifdef RV32IMF_OBI_MEM_STALL_EN
    logic r_stall_q;
    logic w_stall_d;

    always_comb begin
        w_stall_d = w_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_q <= 1'b0;
        end else begin
            r_stall_q <= w_stall_d;
        end
    end

    assign w_stall = r_stall_q;
`else
    assign w_stall = 1'b0;
`endif

    // Storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (w_accept && obi_we_i && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (obi_be_i[b]) begin
                    r_mem_q[w_idx][8*b +: 8] <= obi_wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rsp_in = c_RSP_IDLE;
        if (w_accept) begin
            w_rsp_in.valid = 1'b1;
            w_rsp_in.err   = w_err;
            if (!obi_we_i && !w_err) begin
                w_rsp_in.rdata = r_mem_q[w_idx];
            end
        end
    end

    rv32imf_obi_rsp_pipe #(
        .STAGES (RSP_LATENCY)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_rsp (w_rsp_in),
        .o_rsp (w_rsp_out)
    );

    assign obi_rvalid_o = w_rsp_out.valid;
    assign obi_rdata_o  = w_rsp_out.valid ? w_rsp_out.rdata : 32'h0;
    assign obi_err_o    = w_rsp_out.valid && w_rsp_out.err;

endmodule

`default_nettype wire

// File: tb/tb_rv32imf_obi_mem_responder.sv
// ============================================================================
// Module      : tb_rv32imf_obi_mem_responder
// Description : Randomized scoreboard bench for the OBI memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32imf_obi_mem_responder;

    localparam logic [31:0] c_BASE  = 32'h0000_1000;
    localparam int          c_WORDS = 64;
    localparam int          c_LAT   = 3;
`ifdef RV32IMF_OBI_MEM_STALL_EN
    localparam bit c_STALL = 1'b1;
`else
    localparam bit c_STALL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        obi_req_i;
    logic        obi_gnt_o;
    logic [31:0] obi_addr_i;
    logic        obi_we_i;
    logic [3:0]  obi_be_i;
    logic [31:0] obi_wdata_i;
    logic [5:0]  obi_atop_i;
    logic        obi_rvalid_o;
    logic [31:0] obi_rdata_o;
    logic        obi_err_o;

    rv32imf_obi_mem_responder #(
        .BASE_ADDR   (c_BASE),
        .MEM_WORDS   (c_WORDS),
        .RSP_LATENCY (c_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .obi_req_i    (obi_req_i),
        .obi_gnt_o    (obi_gnt_o),
        .obi_addr_i   (obi_addr_i),
        .obi_we_i     (obi_we_i),
        .obi_be_i     (obi_be_i),
        .obi_wdata_i  (obi_wdata_i),
        .obi_atop_i   (obi_atop_i),
        .obi_rvalid_o (obi_rvalid_o),
        .obi_rdata_o  (obi_rdata_o),
        .obi_err_o    (obi_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [c_WORDS];
    int          tests = 0;
    int          fails = 0;
    bit          prev_acc = 1'b0;

    function automatic bit ref_err(input logic [31:0] addr, input logic [5:0] atop);
        return (addr < c_BASE) || (addr >= c_BASE + 32'(4 * c_WORDS)) || (atop != 6'h0);
    endfunction

    // One bus cycle: drive, check gnt against the model, record the expected response.
    task automatic drive(input bit req, input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [5:0] atop, output bit acc);
        bit   exp_gnt;
        exp_t e;
        int   idx;
        obi_req_i   = req;
        obi_we_i    = we;
        obi_addr_i  = addr;
        obi_be_i    = be;
        obi_wdata_i = wd;
        obi_atop_i  = atop;
        @(negedge clk);
        exp_gnt = req && !rst && !(c_STALL && prev_acc);
        tests++;
        if (obi_gnt_o !== exp_gnt) begin
            fails++;
            $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, obi_gnt_o, exp_gnt);
        end
        acc = exp_gnt;
        if (acc) begin
            e.due   = cyc + c_LAT;
            e.err   = ref_err(addr, atop);
            e.rdata = 32'h0;
            if (!e.err) begin
                idx = int'((addr - c_BASE) >> 2);
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    e.rdata = ref_mem[idx];
                end
            end
            q.push_back(e);
        end
        prev_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [5:0] atop);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 4; t++) begin
            drive(1'b1, we, addr, be, wd, atop, acc);
            if (acc) break;
        end
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL xfer_grant addr=%h got=no_grant exp=grant", addr);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 6'h0, acc);
    endtask

    // Monitor: every cycle, any rvalid must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (obi_rvalid_o === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL rsp_unexpected cyc=%0d got rvalid=1 rdata=%h exp rvalid=0",
                         cyc, obi_rdata_o);
            end else begin
                e = q.pop_front();
                if (obi_rdata_o !== e.rdata || obi_err_o !== e.err || cyc != e.due) begin
                    fails++;
                    $display("FAIL rsp cyc=%0d got rdata=%h err=%b exp rdata=%h err=%b due=%0d",
                             cyc, obi_rdata_o, obi_err_o, e.rdata, e.err, e.due);
                end
            end
        end else begin
            tests++;
            if (obi_rvalid_o !== 1'b0 || obi_rdata_o !== 32'h0 || obi_err_o !== 1'b0) begin
                fails++;
                $display("FAIL idle_outputs cyc=%0d got rvalid=%b rdata=%h err=%b exp 0/0/0",
                         cyc, obi_rvalid_o, obi_rdata_o, obi_err_o);
            end
            if (q.size() > 0 && q[0].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL rsp_missing cyc=%0d got rvalid=0 exp rvalid=1 due=%0d",
                         cyc, q[0].due);
                q.delete(0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          acc;
        logic [31:0] addr;
        rst         = 1'b1;
        obi_req_i   = 1'b0;
        obi_we_i    = 1'b0;
        obi_addr_i  = 32'h0;
        obi_be_i    = 4'h0;
        obi_wdata_i = 32'h0;
        obi_atop_i  = 6'h0;

        // Requests during reset must not be granted.
        drive(1'b1, 1'b0, c_BASE, 4'hF, 32'h0, 6'h0, acc);
        drive(1'b1, 1'b1, c_BASE, 4'hF, 32'h1, 6'h0, acc);
        rst = 1'b0;

        for (int i = 0; i < c_WORDS; i++)
            xfer(1'b1, c_BASE + 32'(4 * i), 4'hF, $urandom, 6'h0);

        // Write then read, partial write.
        xfer(1'b1, c_BASE + 32'h40, 4'hF, 32'hDEAD_BEEF, 6'h0);
        xfer(1'b0, c_BASE + 32'h40, 4'h0, 32'h0, 6'h0);
        xfer(1'b1, c_BASE + 32'h40, 4'hF, 32'h1122_3344, 6'h0);
        xfer(1'b1, c_BASE + 32'h40, 4'b0110, 32'hAABB_CCDD, 6'h0);
        xfer(1'b0, c_BASE + 32'h42, 4'h0, 32'h0, 6'h0);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++)
            xfer(1'b0, c_BASE + 32'(4 * i), 4'hF, 32'h0, 6'h0);

        // Error cases: out of range, below base, atomic write.
        xfer(1'b0, c_BASE + 32'(4 * c_WORDS), 4'hF, 32'h0, 6'h0);
        xfer(1'b0, c_BASE - 32'h4, 4'hF, 32'h0, 6'h0);
        xfer(1'b1, c_BASE + 32'h40, 4'hF, 32'h5555_AAAA, 6'h21);
        xfer(1'b0, c_BASE + 32'h40, 4'hF, 32'h0, 6'h0);
        xfer(1'b1, c_BASE + 32'h40, 4'h0, 32'hFFFF_FFFF, 6'h0);
        xfer(1'b0, c_BASE + 32'h40, 4'hF, 32'h0, 6'h0);
        idle(c_LAT + 1);

        // Reset with two responses in flight.
        xfer(1'b0, c_BASE + 32'h8, 4'hF, 32'h0, 6'h0);
        xfer(1'b0, c_BASE + 32'hC, 4'hF, 32'h0, 6'h0);
        rst = 1'b1;
        q.delete();
        prev_acc = 1'b0;
        drive(1'b1, 1'b0, c_BASE, 4'hF, 32'h0, 6'h0, acc);
        drive(1'b1, 1'b0, c_BASE, 4'hF, 32'h0, 6'h0, acc);
        rst = 1'b0;
        drive(1'b1, 1'b0, c_BASE + 32'h8, 4'hF, 32'h0, 6'h0, acc);
        idle(c_LAT + 1);

        // Held request: exposes the grant pattern in either build.
        for (int i = 0; i < 6; i++)
            drive(1'b1, 1'b0, c_BASE + 32'(4 * i), 4'hF, 32'h0, 6'h0, acc);
        idle(2);

        // Randomized traffic, including out-of-range and atomic requests.
        for (int i = 0; i < 400; i++) begin
            addr = c_BASE - 32'd16 + 32'($urandom_range(0, 4 * c_WORDS + 31));
            drive(($urandom % 4) != 0, $urandom % 2 == 1, addr, 4'($urandom),
                  $urandom, (($urandom % 8) == 0) ? 6'($urandom_range(1, 63)) : 6'h0, acc);
        end

        idle(c_LAT + 3);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0 pending", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rv32imf_obi_mem_responder.md
RV32IMF_OBI_MEM_RESPONDER -- requirements
Module: rv32imf_obi_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words; power of two, minimum 4.
REQ-003 SHALL have parameter RSP_LATENCY, default 1: cycles from grant to rvalid; legal range 1..4.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have ports: clk in 1, clock; rst in 1, async active-high reset.
REQ-006 SHALL have ports: obi_req_i in 1; obi_gnt_o out 1; obi_addr_i in 32; obi_we_i in 1; obi_be_i in 4; obi_wdata_i in 32; obi_atop_i in 6.
REQ-007 SHALL have ports: obi_rvalid_o out 1; obi_rdata_o out 32; obi_err_o out 1.

Function
REQ-008 SHALL define an accepted transfer as obi_req_i && obi_gnt_o at a rising clk edge.
REQ-009 SHALL drive obi_gnt_o combinationally: 1 whenever obi_req_i=1 and rst=0, subject to REQ-020.
REQ-010 SHALL accept one transfer per cycle, with any number of transfers in flight; the response pipeline never stalls.
REQ-011 SHALL index the array with (obi_addr_i - BASE_ADDR)[log2(MEM_WORDS)+1:2] and ignore addr[1:0].
REQ-012 SHALL flag a transfer as an error when the address is outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) or obi_atop_i != 0.
REQ-013 SHALL, for an accepted non-error write, update only the bytes with be[i]=1 at the accepting edge; be=0 is a legal no-op.
REQ-014 SHALL, for an accepted non-error read, capture the full word at the accepting edge, ignoring be; a write accepted in cycle N is visible to a read accepted in cycle N+1.
REQ-015 SHALL perform no array update on an error transfer, and SHALL return rdata=0 and err=1 for it.
REQ-016 SHALL assert obi_rvalid_o exactly RSP_LATENCY cycles after each accepted transfer, for one cycle, in acceptance order.
REQ-017 SHALL return writes with rvalid=1, rdata=0, and err per REQ-012.
REQ-018 SHALL drive obi_rdata_o=0 and obi_err_o=0 whenever obi_rvalid_o=0.

Reset
REQ-019 SHALL, while rst=1:
- force obi_gnt_o=0, obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0;
- clear all response pipeline stages;
- drop in-flight responses without replay;
- leave memory contents unreset.

Configuration
REQ-020 SHALL, with RV32IMF_OBI_MEM_STALL_EN defined, hold obi_gnt_o=0 in the cycle after every accepted transfer, limiting acceptance to at most one transfer per two cycles. Without the macro, obi_gnt_o follows REQ-009.
REQ-021 SHALL, with RV32IMF_OBI_MEM_STALL_EN defined, clear the stall state on reset, so gnt is available in the first cycle after reset release.

Structure
REQ-022 SHALL take from package rv32imf_obi_pkg:
- obi_rsp_t struct {valid, rdata[31:0], err};
- constant OBI_ATOP_NONE = 6'h00.
REQ-023 SHALL implement the latency chain as a sub-module, rv32imf_obi_rsp_pipe: a shift register of obi_rsp_t, RSP_LATENCY stages, with asynchronous clear.

Verification
REQ-024 Write then read: write 0xDEAD_BEEF, be=4'b1111, to 0x40; read 0x40 next cycle -> rvalid one cycle after each grant; read rdata=0xDEAD_BEEF, err=0.
REQ-025 Partial write: word 0x40 = 0x1122_3344; write 0xAABB_CCDD with be=4'b0110 -> next read returns 0x11BB_CC44.
REQ-026 Back-to-back: 4 reads on consecutive cycles, RSP_LATENCY=3 -> 4 consecutive rvalid pulses starting 3 cycles after the first grant, in order.
REQ-027 Errors:
- read of BASE_ADDR+4*MEM_WORDS -> err=1, rdata=0;
- write with atop=6'h21 -> err=1, target word unchanged.
REQ-028 Reset mid-flight: assert rst while 2 responses are pending -> no rvalid during or after reset; gnt=1 on the first req after release.
REQ-029 Stall: with RV32IMF_OBI_MEM_STALL_EN, req held high for 6 cycles -> gnt pattern 1,0,1,0,1,0; 3 responses.
